// File: rtl/aes_req_ctrl.sv
// -----------------------------------------------------------------------------
// aes_req_ctrl
//
// Initiator-side controller for a single-block AES encryption core that uses
// an ld/done handshake. One request at a time is accepted from the tile side,
// its key and plaintext are latched and presented to the core, a one-cycle
// load strobe is issued, and the controller waits for the core's done pulse.
// The ciphertext captured in that cycle is then offered on the output stream
// together with the tag of the request that produced it.
//
// Handshake rules (both streams): a transfer happens in a cycle where valid
// and ready are both high at the rising edge of sys_clk. A producer holds
// valid and its payload stable until the transfer; ready may change freely.
//
// Optional feature (compile-time macro AES_DONE_TIMEOUT_EN):
//   defined   : a wait counter bounds the time spent waiting for aes_done.
//               After TIMEOUT_CYC WAIT cycles without done, the request is
//               dropped, err_timeout is set (sticky) and the FSM returns to
//               IDLE. A done in the expiry cycle still wins.
//   undefined : WAIT lasts until aes_done; err_timeout is tied low and
//               err_clr has no effect.
//
// Parameters:
//   TAG_W        width of the opaque request tag
//   CNT_W        width of the completed-block counter
//   TIMEOUT_CYC  WAIT cycles before abort (optional feature only)
//
// Ports:
//   sys_clk, sys_rst_n            clock, synchronous active-low reset
//   in_valid/in_ready             request stream handshake
//   in_key, in_text, in_tag       request payload
//   out_valid/out_ready           result stream handshake
//   out_text, out_tag             result payload
//   aes_ld                        one-cycle load strobe to the core
//   aes_key, aes_text_in          operands to the core (change only on accept)
//   aes_done, aes_text_out        core completion pulse and result
//   busy                          high whenever the FSM is not IDLE
//   blk_cnt                       count of completed output handshakes (wraps)
//   err_timeout, err_clr          sticky timeout flag and its clear
// -----------------------------------------------------------------------------
module aes_req_ctrl #(
    parameter int TAG_W       = 4,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    // request stream
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:127]     in_key,
    input  logic [0:127]     in_text,
    input  logic [TAG_W-1:0] in_tag,
    // result stream
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:127]     out_text,
    output logic [TAG_W-1:0] out_tag,
    // AES core side
    output logic             aes_ld,
    output logic [0:127]     aes_key,
    output logic [0:127]     aes_text_in,
    input  logic             aes_done,
    input  logic [0:127]     aes_text_out,
    // status
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             err_timeout,
    input  logic             err_clr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_aes_ld;
    logic             r_busy;
    logic [0:127]     r_aes_key;
    logic [0:127]     r_aes_text;
    logic [0:127]     r_out_text;
    logic [TAG_W-1:0] r_tag;
    logic [TAG_W-1:0] r_out_tag;
    logic [CNT_W-1:0] r_blk_cnt;

    logic             w_in_fire;
    logic             w_out_fire;

    // r_in_ready is only ever high in IDLE, so an accept implies IDLE.
    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

`ifdef AES_DONE_TIMEOUT_EN
    // The counter runs 0 .. TIMEOUT_CYC-1, one value per WAIT cycle.
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] r_wait_cnt;
    logic             r_err_timeout;
    logic             w_tmo_hit;

    // Expiry only counts when done is absent; done in the same cycle wins.
    assign w_tmo_hit = (r_state == S_WAIT) && !aes_done && (r_wait_cnt == TMO_LAST);
`endif

    // -------------------------------------------------------------------------
    // Main FSM. All outputs are registered alongside the state so that each
    // output changes in the same edge as the state transition that implies it.
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_aes_ld    <= 1'b0;
            r_busy      <= 1'b0;
            r_aes_key   <= '0;
            r_aes_text  <= '0;
            r_out_text  <= '0;
            r_tag       <= '0;
            r_out_tag   <= '0;
            r_blk_cnt   <= '0;
`ifdef AES_DONE_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_err_timeout <= 1'b0;
`endif
        end else begin
            // The strobe is set only on the accept edge, so it is high for
            // exactly the LOAD cycle and low everywhere else.
            r_aes_ld <= 1'b0;

`ifdef AES_DONE_TIMEOUT_EN
            // Set has priority over a simultaneous clear.
            if (w_tmo_hit) begin
                r_err_timeout <= 1'b1;
            end else if (err_clr) begin
                r_err_timeout <= 1'b0;
            end
`endif

            case (r_state)
                S_IDLE: begin
                    // Also covers the first cycle after reset release.
                    r_in_ready <= 1'b1;
                    if (w_in_fire) begin
                        r_aes_key  <= in_key;
                        r_aes_text <= in_text;
                        r_tag      <= in_tag;
                        r_in_ready <= 1'b0;
                        r_aes_ld   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    r_state <= S_WAIT;
`ifdef AES_DONE_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end

                S_WAIT: begin
                    if (aes_done) begin
                        r_out_text  <= aes_text_out;
                        r_out_tag   <= r_tag;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
`ifdef AES_DONE_TIMEOUT_EN
                    else if (r_wait_cnt == TMO_LAST) begin
                        // Abandon the block: no output, counter untouched.
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TMO_W'(1);
                    end
`endif
                end

                S_HOLD: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_blk_cnt   <= r_blk_cnt + CNT_W'(1);
                        r_busy      <= 1'b0;
                        // Ready rises on the handshake edge so the next
                        // request can be taken in the very next cycle.
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_text    = r_out_text;
    assign out_tag     = r_out_tag;
    assign aes_ld      = r_aes_ld;
    assign aes_key     = r_aes_key;
    assign aes_text_in = r_aes_text;
    assign busy        = r_busy;
    assign blk_cnt     = r_blk_cnt;

`ifdef AES_DONE_TIMEOUT_EN
    assign err_timeout = r_err_timeout;
`else
    // Without the timeout there is nothing to flag; the clear input and the
    // timeout parameter are intentionally left without effect.
    logic w_unused_tmo;
    assign w_unused_tmo = err_clr | (TIMEOUT_CYC < 0);
    assign err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_aes_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_req_ctrl
//
// Directed bench for aes_req_ctrl. A small behavioural core answers each load
// strobe after core_lat cycles with a stand-in cipher function (the FIPS-197
// vector maps to its real ciphertext). A second instance with CNT_W=2 shares
// all inputs and is used to observe counter wrap.
// -----------------------------------------------------------------------------
module tb_aes_req_ctrl;

    localparam int TAG_W = 4;
    localparam int CNT_W = 16;
    localparam int TMO   = 8;
`ifdef AES_DONE_TIMEOUT_EN
    localparam int LCORE = 5;
`else
    localparam int LCORE = 10;
`endif

    localparam logic [0:127] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // ---------------- clock / reset ----------------
    logic sys_clk;
    logic sys_rst_n;
    int   cyc = 0;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic             in_valid;
    logic             in_ready;
    logic [0:127]     in_key;
    logic [0:127]     in_text;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [0:127]     out_text;
    logic [TAG_W-1:0] out_tag;
    logic             aes_ld;
    logic [0:127]     aes_key;
    logic [0:127]     aes_text_in;
    logic             aes_done;
    logic [0:127]     aes_text_out;
    logic             busy;
    logic [CNT_W-1:0] blk_cnt;
    logic             err_timeout;
    logic             err_clr;

    logic             d2_in_ready;
    logic             d2_out_valid;
    logic [0:127]     d2_out_text;
    logic [TAG_W-1:0] d2_out_tag;
    logic             d2_aes_ld;
    logic [0:127]     d2_aes_key;
    logic [0:127]     d2_aes_text_in;
    logic             d2_busy;
    logic [1:0]       d2_blk_cnt;
    logic             d2_err_timeout;

    aes_req_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_key(in_key), .in_text(in_text), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_text(out_text), .out_tag(out_tag),
        .aes_ld(aes_ld), .aes_key(aes_key), .aes_text_in(aes_text_in),
        .aes_done(aes_done), .aes_text_out(aes_text_out),
        .busy(busy), .blk_cnt(blk_cnt),
        .err_timeout(err_timeout), .err_clr(err_clr)
    );

    aes_req_ctrl #(.TAG_W(TAG_W), .CNT_W(2), .TIMEOUT_CYC(TMO)) u_dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .in_valid(in_valid), .in_ready(d2_in_ready),
        .in_key(in_key), .in_text(in_text), .in_tag(in_tag),
        .out_valid(d2_out_valid), .out_ready(out_ready),
        .out_text(d2_out_text), .out_tag(d2_out_tag),
        .aes_ld(d2_aes_ld), .aes_key(d2_aes_key), .aes_text_in(d2_aes_text_in),
        .aes_done(aes_done), .aes_text_out(aes_text_out),
        .busy(d2_busy), .blk_cnt(d2_blk_cnt),
        .err_timeout(d2_err_timeout), .err_clr(err_clr)
    );

    // ---------------- scoreboard state ----------------
    int               total = 0;
    int               bad   = 0;
    int               exp_cnt = 0;
    logic [0:127]     exp_q[$];
    logic [TAG_W-1:0] tag_q[$];

    // ---------------- core model ----------------
    bit           core_en  = 1'b1;
    bit           kick     = 1'b0;
    int           core_lat = LCORE;
    int           core_cnt = 0;
    logic [0:127] core_key;
    logic [0:127] core_txt;

    function automatic logic [0:127] fake_ct(input logic [0:127] k, input logic [0:127] t);
        if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
        return k ^ {t[64:127], t[0:63]};
    endfunction

    // Runs 2 time units after each edge so test tasks (at +1) can request a
    // forced done pulse via kick for the same cycle. Not reset with the DUT,
    // so an in-flight completion still arrives after a mid-WAIT reset.
    initial begin
        aes_done     = 1'b0;
        aes_text_out = '0;
        core_key     = '0;
        core_txt     = '0;
        forever begin
            @(posedge sys_clk);
            #2;
            aes_done = 1'b0;
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    aes_done     = 1'b1;
                    aes_text_out = fake_ct(core_key, core_txt);
                end
            end
            if (kick) begin
                kick         = 1'b0;
                aes_done     = 1'b1;
                aes_text_out = fake_ct(aes_key, aes_text_in);
            end
            if (aes_ld === 1'b1 && core_en) begin
                core_cnt = core_lat;
                core_key = aes_key;
                core_txt = aes_text_in;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Offers one request; returns the cycle in which it was accepted.
    task automatic send(input logic [0:127] k, input logic [0:127] t,
                        input logic [TAG_W-1:0] g, output int t_acc, output bit ok);
        in_valid = 1'b1;
        in_key   = k;
        in_text  = t;
        in_tag   = g;
        ok       = 1'b0;
        t_acc    = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (in_ready === 1'b1) begin
                ok    = 1'b1;
                t_acc = cyc;
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    // Waits for out_valid; counts load strobes seen on the way.
    task automatic wait_out(output bit seen, output int c, output int ld_n);
        seen = 1'b0;
        c    = 0;
        ld_n = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                c    = cyc;
            end else begin
                if (aes_ld === 1'b1) ld_n++;
                step();
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sys_rst_n = 1'b0;
        step();
        step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0h want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0h want=0", out_valid); end
        total++; if (aes_ld !== 1'b0) begin bad++; $display("FAIL rst_aes_ld got=%0h want=0", aes_ld); end
        total++; if (out_text !== 128'h0) begin bad++; $display("FAIL rst_out_text got=%h want=0", out_text); end
        total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL rst_out_tag got=%h want=0", out_tag); end
        total++; if (aes_key !== 128'h0) begin bad++; $display("FAIL rst_aes_key got=%h want=0", aes_key); end
        total++; if (aes_text_in !== 128'h0) begin bad++; $display("FAIL rst_aes_text_in got=%h want=0", aes_text_in); end
        total++; if (blk_cnt !== 16'h0) begin bad++; $display("FAIL rst_blk_cnt got=%0d want=0", blk_cnt); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rst_err got=%0h want=0", err_timeout); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h want=0", busy); end
        sys_rst_n = 1'b1;
        step();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0h want=1", in_ready); end
        exp_cnt = 0;
    endtask

    task automatic test_single();
        int t, c, ldn;
        bit ok, seen;
        out_ready = 1'b1;
        send(FIPS_KEY, FIPS_PT, 4'h3, t, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_accept got=timeout want=accept"); end
        total++; if (aes_ld !== 1'b1) begin bad++; $display("FAIL single_ld_t1 got=%0h want=1", aes_ld); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%0h want=1", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL single_in_ready got=%0h want=0", in_ready); end
        step();
        total++; if (aes_ld !== 1'b0) begin bad++; $display("FAIL single_ld_t2 got=%0h want=0", aes_ld); end
        wait_out(seen, c, ldn);
        total++; if (!seen) begin bad++; $display("FAIL single_out_valid got=timeout want=valid"); end
        total++; if (c != t + 2 + LCORE) begin bad++; $display("FAIL single_latency got=%0d want=%0d", c - t, 2 + LCORE); end
        total++; if (ldn != 0) begin bad++; $display("FAIL single_extra_ld got=%0d want=0", ldn); end
        total++; if (out_text !== FIPS_CT) begin bad++; $display("FAIL single_text got=%h want=%h", out_text, FIPS_CT); end
        total++; if (out_tag !== 4'h3) begin bad++; $display("FAIL single_tag got=%h want=3", out_tag); end
        total++; if (aes_key !== FIPS_KEY) begin bad++; $display("FAIL single_key_hold got=%h want=%h", aes_key, FIPS_KEY); end
        step();
        exp_cnt++;
        total++; if (blk_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL single_blk_cnt got=%0d want=%0d", blk_cnt, exp_cnt); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_valid_drop got=%0h want=0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [0:127] k1, t1, k2, t2;
        int t, c, ldn, errs;
        bit ok, seen;
        k1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        t1 = 128'hdead_beef_0000_ffff_0123_4567_89ab_cdef;
        k2 = 128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100;
        t2 = 128'hcafe_f00d_1234_5678_9abc_def0_0bad_c0de;
        out_ready = 1'b0;
        send(k1, t1, 4'h5, t, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_accept got=timeout want=accept"); end
        wait_out(seen, c, ldn);
        total++; if (!seen) begin bad++; $display("FAIL bp_out_valid got=timeout want=valid"); end
        total++; if (out_text !== fake_ct(k1, t1)) begin bad++; $display("FAIL bp_text got=%h want=%h", out_text, fake_ct(k1, t1)); end
        in_valid = 1'b1;
        in_key   = k2;
        in_text  = t2;
        in_tag   = 4'h6;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid !== 1'b1 || out_text !== fake_ct(k1, t1) || out_tag !== 4'h5 ||
                in_ready !== 1'b0 || aes_key !== k1 || aes_ld !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL bp_hold_stable got=%0d bad cycles want=0", errs); end
        out_ready = 1'b1;
        step();
        exp_cnt++;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop got=%0h want=0", out_valid); end
        total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle got busy=%0h rdy=%0h want busy=0 rdy=1", busy, in_ready); end
        total++; if (blk_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL bp_blk_cnt got=%0d want=%0d", blk_cnt, exp_cnt); end
        step();
        in_valid = 1'b0;
        total++; if (aes_ld !== 1'b1 || aes_key !== k2) begin bad++; $display("FAIL bp_next_accept got ld=%0h key=%h want ld=1 key=%h", aes_ld, aes_key, k2); end
        wait_out(seen, c, ldn);
        total++; if (!seen || out_text !== fake_ct(k2, t2) || out_tag !== 4'h6) begin
            bad++; $display("FAIL bp_second got=%h/%h want=%h/6", out_text, out_tag, fake_ct(k2, t2)); end
        step();
        exp_cnt++;
        total++; if (blk_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL bp_blk_cnt2 got=%0d want=%0d", blk_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        int ld_tot;
        out_ready = 1'b1;
        ld_tot    = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    logic [0:127] k, t;
                    int tt;
                    bit ok;
                    k = {4{32'ha5a5_0000 + 32'(i)}};
                    t = {4{32'h1000_0001 * 32'(i + 3)}};
                    exp_q.push_back(fake_ct(k, t));
                    tag_q.push_back(4'(i + 8));
                    send(k, t, 4'(i + 8), tt, ok);
                    total++; if (!ok) begin bad++; $display("FAIL b2b_accept%0d got=timeout want=accept", i); end
                end
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    logic [0:127]     e;
                    logic [TAG_W-1:0] g;
                    int c, ldn;
                    bit seen;
                    wait_out(seen, c, ldn);
                    ld_tot += ldn;
                    if (!seen) begin
                        total++; bad++; $display("FAIL b2b_out%0d got=timeout want=valid", i);
                    end else begin
                        e = exp_q.pop_front();
                        g = tag_q.pop_front();
                        total++; if (out_text !== e) begin bad++; $display("FAIL b2b_text%0d got=%h want=%h", i, out_text, e); end
                        total++; if (out_tag !== g) begin bad++; $display("FAIL b2b_tag%0d got=%h want=%h", i, out_tag, g); end
                        exp_cnt++;
                    end
                    step();
                end
            end
        join
        total++; if (ld_tot != 5) begin bad++; $display("FAIL b2b_ld_pulses got=%0d want=5", ld_tot); end
        total++; if (blk_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL b2b_blk_cnt got=%0d want=%0d", blk_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid_wait();
        int t, errs;
        bit ok;
        out_ready = 1'b1;
        send(128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef, 128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa,
             4'h9, t, ok);
        total++; if (!ok || aes_ld !== 1'b1) begin bad++; $display("FAIL mid_ld got ok=%0d ld=%0h want ok=1 ld=1", ok, aes_ld); end
        step();
        step();
        step();
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
        exp_cnt = 0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || aes_ld !== 1'b0) begin
            bad++; $display("FAIL mid_rst_ctrl got v=%0h b=%0h r=%0h ld=%0h want 0000", out_valid, busy, in_ready, aes_ld); end
        total++; if (aes_key !== 128'h0 || aes_text_in !== 128'h0 || out_text !== 128'h0 || out_tag !== 4'h0) begin
            bad++; $display("FAIL mid_rst_data got key=%h txt=%h out=%h tag=%h want 0", aes_key, aes_text_in, out_text, out_tag); end
        total++; if (blk_cnt !== 16'h0) begin bad++; $display("FAIL mid_rst_cnt got=%0d want=0", blk_cnt); end
        // The core's completion arrives LCORE cycles after the strobe.
        errs = 0;
        for (int i = 0; i < LCORE + 4; i++) begin
            step();
            if (out_valid !== 1'b0 || busy !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL mid_late_done got=%0d bad cycles want=0", errs); end
    endtask

    task automatic test_wrap();
        logic [1:0] wrap_exp[5];
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [0:127] k, t;
            int tt, c, ldn;
            bit ok, seen;
            k = {8{16'h7700 + 16'(i)}};
            t = {8{16'h0099 ^ 16'(i * 5)}};
            send(k, t, 4'(i), tt, ok);
            wait_out(seen, c, ldn);
            total++; if (!seen || out_text !== fake_ct(k, t)) begin
                bad++; $display("FAIL wrap_text%0d got=%h want=%h", i, out_text, fake_ct(k, t)); end
            step();
            exp_cnt++;
            total++; if (d2_blk_cnt !== wrap_exp[i]) begin bad++; $display("FAIL wrap_cnt%0d got=%0d want=%0d", i, d2_blk_cnt, wrap_exp[i]); end
            total++; if (blk_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL wrap_wide%0d got=%0d want=%0d", i, blk_cnt, exp_cnt); end
        end
    endtask

`ifdef AES_DONE_TIMEOUT_EN
    task automatic test_timeout();
        logic [0:127] k, t;
        int tt, c, ldn;
        bit ok, seen;
        k = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        t = 128'h3243f6a8_885a308d_313198a2_e0370734;
        out_ready = 1'b1;
        // Done in the expiry cycle: normal completion, no error.
        core_lat = TMO;
        send(k, t, 4'h2, tt, ok);
        wait_out(seen, c, ldn);
        total++; if (!seen || out_text !== fake_ct(k, t)) begin bad++; $display("FAIL tmo_edge_done got=%h want=%h", out_text, fake_ct(k, t)); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL tmo_edge_err got=%0h want=0", err_timeout); end
        step();
        exp_cnt++;
        core_lat = LCORE;
        // Core never answers.
        core_en = 1'b0;
        send(k, t, 4'h4, tt, ok);
        for (int i = 0; i < TMO; i++) step();
        total++; if (err_timeout !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL tmo_before got err=%0h busy=%0h want 0/1", err_timeout, busy); end
        step();
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL tmo_err got=%0h want=1", err_timeout); end
        total++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL tmo_idle got b=%0h r=%0h v=%0h want 0/1/0", busy, in_ready, out_valid); end
        total++; if (blk_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL tmo_blk_cnt got=%0d want=%0d", blk_cnt, exp_cnt); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL tmo_clr got=%0h want=0", err_timeout); end
        core_en = 1'b1;
    endtask
`else
    task automatic test_timeout();
        logic [0:127] k, t;
        int tt, c, ldn, errs;
        bit ok, seen;
        k = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        t = 128'h3243f6a8_885a308d_313198a2_e0370734;
        out_ready = 1'b1;
        core_en   = 1'b0;
        send(k, t, 4'h4, tt, ok);
        errs = 0;
        for (int i = 0; i < 4 * TMO; i++) begin
            step();
            if (busy !== 1'b1 || err_timeout !== 1'b0 || out_valid !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL notmo_wait got=%0d bad cycles want=0", errs); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        total++; if (err_timeout !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL notmo_clr got err=%0h busy=%0h want 0/1", err_timeout, busy); end
        kick = 1'b1;
        wait_out(seen, c, ldn);
        total++; if (!seen || out_text !== fake_ct(k, t) || out_tag !== 4'h4) begin
            bad++; $display("FAIL notmo_done got=%h/%h want=%h/4", out_text, out_tag, fake_ct(k, t)); end
        step();
        exp_cnt++;
        total++; if (blk_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL notmo_blk_cnt got=%0d want=%0d", blk_cnt, exp_cnt); end
        core_en = 1'b1;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        in_key    = '0;
        in_text   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        #1;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        test_wrap();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
